// File: rtl/mem_responder.sv
// Memory-side responder with a DEPTH x MEM_W SRAM, byte-enable writes and range errors.
// Registered responses LATENCY cycles after accept. There is no back-pressure.
module mem_responder #(
   parameter int          MEM_W     = 32,
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LATENCY   = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               mem_req_i,
   input  logic [31:0]        mem_addr_i,
   input  logic               mem_we_i,
   input  logic [MEM_W/8-1:0] mem_be_i,
   input  logic [MEM_W-1:0]   mem_wdata_i,
   output logic               mem_rvalid_o,
   output logic               mem_err_o,
   output logic [MEM_W-1:0]   mem_rdata_o,
   output logic [31:0]        cnt_rd_o,
   output logic [31:0]        cnt_wr_o,
   output logic [31:0]        cnt_err_o
);

   localparam int BE_W  = MEM_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic             vld;
      logic             err;
      logic [MEM_W-1:0] dat;
   } rsp_t;

   generate
      if (LATENCY < 1 || LATENCY > 31) begin : g_bad_latency
         $error("mem_responder: LATENCY must be in 1..31");
      end
      if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("mem_responder: DEPTH must be a power of 2");
      end
      if (MEM_W < 8 || (MEM_W & (MEM_W - 1)) != 0) begin : g_bad_width
         $error("mem_responder: MEM_W must be a power of 2");
      end
   endgenerate

   logic [31:0]      addr_off;
   logic [31:0]      word_idx;
   logic             in_range;
   logic [IDX_W-1:0] ram_idx;
   logic             acc_vld;
   logic             rd_vld;
   logic             wr_vld;
   logic             err_vld;
   rsp_t             rsp_new;

   logic [MEM_W-1:0] ram [DEPTH];
   rsp_t             rsp_pipe [LATENCY];

   // Unsigned subtract: addresses below BASE_ADDR wrap high and are also caught by the compare.
   always_comb begin
      addr_off = mem_addr_i - BASE_ADDR;
      word_idx = addr_off >> OFF_W;
      in_range = (mem_addr_i >= BASE_ADDR) && (word_idx < 32'(DEPTH));
      ram_idx  = word_idx[IDX_W-1:0];
      acc_vld  = mem_req_i && !rst_i;
      rd_vld   = acc_vld && in_range && !mem_we_i;
      wr_vld   = acc_vld && in_range && mem_we_i;
      err_vld  = acc_vld && !in_range;
      rsp_new.vld = acc_vld;
      rsp_new.err = err_vld;
      rsp_new.dat = rd_vld ? ram[ram_idx] : '0;
   end

   always_ff @(posedge clk_i) begin
      if (wr_vld) begin
         for (int b = 0; b < BE_W; b++) begin
            if (mem_be_i[b]) begin
               ram[ram_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Whole stages are cleared on reset so idle outputs read as zero, not stale data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            rsp_pipe[i] <= '0;
         end
      end else begin
         rsp_pipe[0] <= rsp_new;
         for (int i = 1; i < LATENCY; i++) begin
            rsp_pipe[i] <= rsp_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_rd_o  <= '0;
         cnt_wr_o  <= '0;
         cnt_err_o <= '0;
      end else begin
         if (rd_vld)  cnt_rd_o  <= cnt_rd_o + 32'd1;
         if (wr_vld)  cnt_wr_o  <= cnt_wr_o + 32'd1;
         if (err_vld) cnt_err_o <= cnt_err_o + 32'd1;
      end
   end

   assign mem_rvalid_o = rsp_pipe[LATENCY-1].vld;
   assign mem_err_o    = rsp_pipe[LATENCY-1].err;
   assign mem_rdata_o  = rsp_pipe[LATENCY-1].dat;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (varied LATENCY/BASE_ADDR) share one stimulus stream
// and are each scored against a per-instance word-array and response-schedule model.
module tb_mem_responder;

   localparam int NDUT  = 4;
   localparam int DEPTH = 4096;
   localparam int RING  = 64;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         2:       return 7;
         default: return 2;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 3) ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  mem_req = 1'b0;
   logic                  mem_we = 1'b0;
   logic [3:0]            mem_be = '0;
   logic [31:0]           mem_addr = '0;
   logic [31:0]           mem_wdata = '0;
   logic [NDUT-1:0]       rvalid;
   logic [NDUT-1:0]       rerr;
   logic [NDUT-1:0][31:0] rdata;
   logic [NDUT-1:0][31:0] cnt_rd;
   logic [NDUT-1:0][31:0] cnt_wr;
   logic [NDUT-1:0][31:0] cnt_err;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mem_responder #(
         .MEM_W     (32),
         .DEPTH     (DEPTH),
         .BASE_ADDR (base_of(g)),
         .LATENCY   (lat_of(g))
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .mem_req_i    (mem_req),
         .mem_addr_i   (mem_addr),
         .mem_we_i     (mem_we),
         .mem_be_i     (mem_be),
         .mem_wdata_i  (mem_wdata),
         .mem_rvalid_o (rvalid[g]),
         .mem_err_o    (rerr[g]),
         .mem_rdata_o  (rdata[g]),
         .cnt_rd_o     (cnt_rd[g]),
         .cnt_wr_o     (cnt_wr[g]),
         .cnt_err_o    (cnt_err[g])
      );
   end

   always #5 clk = ~clk;

   // Reference model: word array, known-word flags, responses scheduled by due edge.
   logic [31:0] mdl_mem   [NDUT][DEPTH];
   bit          mdl_known [NDUT][DEPTH];
   bit          exp_vld   [NDUT][RING];
   bit          exp_err   [NDUT][RING];
   bit          exp_chk   [NDUT][RING];
   logic [31:0] exp_dat   [NDUT][RING];
   logic [31:0] mdl_rd    [NDUT];
   logic [31:0] mdl_wr    [NDUT];
   logic [31:0] mdl_err   [NDUT];
   int          edge_cnt = 0;
   int          nchk = 0;
   int          nfail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   task automatic model_edge(input bit r, input bit req, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] off;
      int          idx;
      bit          ok;
      bit          e;
      bit          c;
      logic [31:0] d;
      int          slot;
      for (int k = 0; k < NDUT; k++) begin
         if (r) begin
            for (int s = 0; s < RING; s++) exp_vld[k][s] = 1'b0;
            mdl_rd[k]  = '0;
            mdl_wr[k]  = '0;
            mdl_err[k] = '0;
         end else if (req) begin
            off = addr - base_of(k);
            ok  = (addr >= base_of(k)) && ((off / 4) < DEPTH);
            e = 1'b0;
            c = 1'b1;
            d = '0;
            if (!ok) begin
               e = 1'b1;
               mdl_err[k]++;
            end else begin
               idx = int'(off / 4);
               if (we) begin
                  for (int b = 0; b < 4; b++)
                     if (be[b]) mdl_mem[k][idx][8*b +: 8] = wd[8*b +: 8];
                  if (be == 4'hF) mdl_known[k][idx] = 1'b1;
                  mdl_wr[k]++;
               end else begin
                  d = mdl_mem[k][idx];
                  c = mdl_known[k][idx];
                  mdl_rd[k]++;
               end
            end
            slot = (edge_cnt + lat_of(k) - 1) % RING;
            exp_vld[k][slot] = 1'b1;
            exp_err[k][slot] = e;
            exp_chk[k][slot] = c;
            exp_dat[k][slot] = d;
         end
      end
   endtask

   task automatic check_outputs();
      int slot;
      bit ev;
      slot = edge_cnt % RING;
      for (int k = 0; k < NDUT; k++) begin
         ev = exp_vld[k][slot];
         check($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(ev));
         check($sformatf("err%0d", k), 32'(rerr[k]), ev ? 32'(exp_err[k][slot]) : 32'd0);
         if (!ev || exp_chk[k][slot])
            check($sformatf("rdata%0d", k), rdata[k], ev ? exp_dat[k][slot] : 32'd0);
         exp_vld[k][slot] = 1'b0;
         check($sformatf("cnt_rd%0d", k), cnt_rd[k], mdl_rd[k]);
         check($sformatf("cnt_wr%0d", k), cnt_wr[k], mdl_wr[k]);
         check($sformatf("cnt_err%0d", k), cnt_err[k], mdl_err[k]);
      end
   endtask

   task automatic step(input bit r, input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
      rst       = r;
      mem_req   = req;
      mem_we    = we;
      mem_be    = be;
      mem_addr  = addr;
      mem_wdata = wd;
      @(posedge clk);
      model_edge(r, req, we, be, addr, wd);
      @(negedge clk);
      check_outputs();
      edge_cnt++;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
      step(1'b0, 1'b1, 1'b1, be, addr, wd);
   endtask

   task automatic rd(input logic [31:0] addr);
      step(1'b0, 1'b1, 1'b0, 4'($urandom), addr, $urandom);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
   endtask

   initial begin
      logic [31:0] a;
      int          p;
      for (int k = 0; k < NDUT; k++) begin
         mdl_rd[k] = '0; mdl_wr[k] = '0; mdl_err[k] = '0;
         for (int s = 0; s < RING; s++) exp_vld[k][s] = 1'b0;
         for (int i = 0; i < DEPTH; i++) mdl_known[k][i] = 1'b0;
      end

      step(1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Write then read
      wr(32'h100, 4'hF, 32'hDEAD_BEEF);
      rd(32'h100);
      check("wr_rd_data", rdata[0], 32'hDEAD_BEEF);
      check("wr_rd_cnt_wr", cnt_wr[0], 32'd1);
      check("wr_rd_cnt_rd", cnt_rd[0], 32'd1);

      // Byte enables
      wr(32'h200, 4'hF, 32'h1122_3344);
      wr(32'h200, 4'b0101, 32'hAABB_CCDD);
      rd(32'h200);
      check("be_data", rdata[0], 32'h11BB_33DD);

      // Out of range
      rd(32'h4000);
      check("oor_err", 32'(rerr[0]), 32'd1);
      check("oor_data", rdata[0], 32'd0);
      check("oor_cnt", cnt_err[0], 32'd1);

      // Latency / throughput on the LATENCY=3 instance
      for (int i = 0; i < 8; i++) wr(32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i));
      for (int i = 0; i < 8; i++) rd(32'(i * 4));
      for (int i = 0; i < 8; i++) idle();

      // Reset with responses in flight
      rd(32'h100);
      rd(32'h200);
      wr(32'h300, 4'hF, 32'h1234_5678);
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int i = 0; i < 10; i++) idle();
      check("rst_cnt_rd", cnt_rd[2], 32'd0);
      check("rst_cnt_wr", cnt_wr[2], 32'd0);
      check("rst_cnt_err", cnt_err[3], 32'd0);
      rd(32'h100);
      check("rst_keep_data", rdata[0], 32'hDEAD_BEEF);

      // Fill every word any instance can address
      for (int i = 0; i < 32'h5000; i += 4) wr(32'(i), 4'hF, $urandom);

      // Random mix
      for (int n = 0; n < 10000; n++) begin
         p = int'($urandom_range(0, 99));
         if      (p < 5)  a = 32'h0001_0000 | $urandom;
         else if (p < 40) a = $urandom_range(0, 63);
         else if (p < 55) a = 32'h3FC0 + $urandom_range(0, 127);
         else if (p < 70) a = 32'h0FC0 + $urandom_range(0, 127);
         else             a = $urandom_range(0, 32'h4FFF);
         if ($urandom_range(0, 1999) == 0)
            step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
         else if ($urandom_range(0, 99) < 15)
            idle();
         else
            step(1'b0, 1'b1, 1'($urandom), 4'($urandom), a, $urandom);
      end

      for (int i = 0; i < 10; i++) idle();

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
